// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: iterative RV32M multiply/divide unit for the E->M boundary.
// The shared accumulator holds {hi, multiplier} during MUL and {remainder, quotient}
// during DIV; operand magnitudes are processed and the sign is fixed up on the way out.
// Build option: define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a
// single-cycle 2*XLEN multiplier (divide is unaffected; ports are identical).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for StartE; the only state that accepts an operation
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | DoneM high for one cycle with ResultM/RdM valid
module rv32m_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST_N,
    input  logic            StartE,
    input  logic [2:0]      OpE,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    input  logic [4:0]      RdE,
    input  logic            Flush,
    output logic            Busy,
    output logic            DoneM,
    output logic [XLEN-1:0] ResultM,
    output logic [4:0]      RdM
);

    localparam int CntW = $clog2(XLEN) + 1;
    localparam logic [CntW-1:0] DivIters = CntW'(XLEN);
`ifdef MULDIV_FAST_MUL_EN
    localparam logic [CntW-1:0] MulIters = CntW'(1);
`else
    localparam logic [CntW-1:0] MulIters = CntW'(XLEN);
`endif
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT state;
    stateT stateNext;

    // Operation decode on the request side (only meaningful at acceptance)
    logic            accept;
    logic            isDivE;
    logic            op1SignedE;
    logic            op2SignedE;
    logic            sign1E;
    logic            sign2E;
    logic            divByZeroE;
    logic            divOverflowE;
    logic            specialE;
    logic [XLEN-1:0] mag1E;
    logic [XLEN-1:0] mag2E;
    logic [XLEN-1:0] specialResE;

    assign accept       = (state == IDLE) && StartE && !Flush;
    assign isDivE       = OpE[2];
    // MUL/MULH: both signed, MULHSU: rs1 signed only, MULHU: neither; DIV/REM signed, DIVU/REMU not
    assign op1SignedE   = isDivE ? ~OpE[0] : (OpE[1:0] != 2'b11);
    assign op2SignedE   = isDivE ? ~OpE[0] : ~OpE[1];
    assign sign1E       = op1SignedE & Operand1[XLEN-1];
    assign sign2E       = op2SignedE & Operand2[XLEN-1];
    assign mag1E        = sign1E ? -Operand1 : Operand1;
    assign mag2E        = sign2E ? -Operand2 : Operand2;
    assign divByZeroE   = isDivE && (Operand2 == '0);
    assign divOverflowE = isDivE && !OpE[0] && (Operand1 == MinNeg) && (Operand2 == '1);
    assign specialE     = divByZeroE | divOverflowE;
    // Divide-by-zero wins over overflow (divisor -1 and 0 are mutually exclusive anyway)
    assign specialResE  = divByZeroE ? (OpE[1] ? Operand1 : '1)
                                     : (OpE[1] ? '0 : MinNeg);

    // Registered operation context
    logic [1:0]        opReg;
    logic [4:0]        rdReg;
    logic              negRes;
    logic              negRem;
    logic [CntW-1:0]   cnt;
    logic [2*XLEN-1:0] accReg;
    logic [XLEN-1:0]   bReg;
    logic              lastIter;

    assign lastIter = (cnt <= CntW'(1));

    // Multiply step: accReg = {partial high, remaining multiplier}, bReg = multiplicand
    logic [2*XLEN-1:0] mulNext;
`ifdef MULDIV_FAST_MUL_EN
    assign mulNext = {{XLEN{1'b0}}, accReg[XLEN-1:0]} * {{XLEN{1'b0}}, bReg};
`else
    logic [XLEN:0] mulSum;
    assign mulSum  = {1'b0, accReg[2*XLEN-1:XLEN]} + (accReg[0] ? {1'b0, bReg} : '0);
    assign mulNext = {mulSum, accReg[XLEN-1:1]};
`endif

    // Restoring divide step: accReg = {partial remainder, dividend/quotient}, bReg = divisor
    logic [XLEN:0]     divTrial;
    logic [XLEN:0]     divDiff;
    logic              divBit;
    logic [XLEN-1:0]   remNext;
    logic [2*XLEN-1:0] divNext;

    assign divTrial = {accReg[2*XLEN-1:XLEN], accReg[XLEN-1]};
    assign divDiff  = divTrial - {1'b0, bReg};
    assign divBit   = ~divDiff[XLEN];
    assign remNext  = divBit ? divDiff[XLEN-1:0] : divTrial[XLEN-1:0];
    assign divNext  = {remNext, accReg[XLEN-2:0], divBit};

    // Sign fix-up applied to the value produced by the final iteration
    logic [2*XLEN-1:0] mulSigned;
    logic [XLEN-1:0]   mulRes;
    logic [XLEN-1:0]   quoFinal;
    logic [XLEN-1:0]   remFinal;
    logic [XLEN-1:0]   divRes;

    assign mulSigned = negRes ? -mulNext : mulNext;
    assign mulRes    = (opReg == 2'b00) ? mulSigned[XLEN-1:0] : mulSigned[2*XLEN-1:XLEN];
    assign quoFinal  = negRes ? -divNext[XLEN-1:0] : divNext[XLEN-1:0];
    assign remFinal  = negRem ? -divNext[2*XLEN-1:XLEN] : divNext[2*XLEN-1:XLEN];
    assign divRes    = opReg[1] ? remFinal : quoFinal;

    // State register
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; Flush overrides everything and returns to IDLE
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (specialE) begin
                        stateNext = DONE;
                    end else if (isDivE) begin
                        stateNext = DIV;
                    end else begin
                        stateNext = MUL;
                    end
                end
            end
            MUL, DIV: begin
                if (lastIter) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (Flush) begin
            stateNext = IDLE;
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        Busy  = (state != IDLE);
        DoneM = (state == DONE);
    end

    // Datapath: capture at acceptance, then one iteration per cycle in MUL/DIV
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            opReg  <= '0;
            rdReg  <= '0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            cnt    <= '0;
            accReg <= '0;
            bReg   <= '0;
        end else if (accept) begin
            opReg  <= OpE[1:0];
            rdReg  <= RdE;
            negRes <= sign1E ^ sign2E;
            negRem <= sign1E;
            if (isDivE) begin
                cnt    <= DivIters;
                accReg <= {{XLEN{1'b0}}, mag1E};
                bReg   <= mag2E;
            end else begin
                cnt    <= MulIters;
                accReg <= {{XLEN{1'b0}}, mag2E};
                bReg   <= mag1E;
            end
        end else if ((state == MUL) || (state == DIV)) begin
            if (cnt != '0) begin
                cnt <= cnt - CntW'(1);
            end
            accReg <= (state == MUL) ? mulNext : divNext;
        end
    end

    // Result/tag registers load only on the way into DONE and hold otherwise
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            ResultM <= '0;
            RdM     <= '0;
        end else if (stateNext == DONE) begin
            case (state)
                IDLE: begin
                    ResultM <= specialResE;
                    RdM     <= RdE;
                end
                MUL: begin
                    ResultM <= mulRes;
                    RdM     <= rdReg;
                end
                default: begin
                    ResultM <= divRes;
                    RdM     <= rdReg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Testbench for rv32m_muldiv_unit: directed operations against an arithmetic
// reference model, with a per-cycle compare process and literal pins.
module tb_rv32m_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = XLEN + 1;
`endif
    localparam int DivLat = XLEN + 1;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        startE = 1'b0;
    logic [2:0]  opE = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  rdE = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        doneM;
    logic [31:0] resultM;
    logic [4:0]  rdM;

    rv32m_muldiv_unit #(.XLEN(XLEN)) dut (
        .CPU_CLK  (clk),
        .CPU_RST_N(rstN),
        .StartE   (startE),
        .OpE      (opE),
        .Operand1 (op1),
        .Operand2 (op2),
        .RdE      (rdE),
        .Flush    (flush),
        .Busy     (busy),
        .DoneM    (doneM),
        .ResultM  (resultM),
        .RdM      (rdM)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Expected-behaviour model state
    bit          pValid = 1'b0;
    int          pAcc = 0;
    int          pDone = 0;
    int          pKill = 0;
    logic [31:0] pRes = '0;
    logic [4:0]  pRd = '0;
    logic [31:0] mRes = '0;
    logic [4:0]  mRd = '0;
    logic [31:0] gotRes = '0;
    int          gotLat = 0;
    bit          cActive;
    bit          cDone;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        int ia;
        int ib;
        ia = a;
        ib = b;
        p = '0;
        r = '0;
        case (op)
            3'd0, 3'd1: p = 64'(longint'(ia) * longint'(ib));
            3'd2:       p = 64'(longint'(ia) * longint'({32'b0, b}));
            3'd3:       p = {32'b0, a} * {32'b0, b};
            default:    p = '0;
        endcase
        case (op)
            3'd0: r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = 32'(ia / ib);
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else r = 32'(ia % ib);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int expLat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int l;
        if (!op[2]) l = MulLat;
        else if (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) l = 1;
        else l = DivLat;
        return l;
    endfunction

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        cActive = pValid && (cyc >= pAcc) && (cyc <= pDone) && (cyc < pKill);
        cDone   = cActive && (cyc == pDone);
        if (cDone) begin
            mRes = pRes;
            mRd  = pRd;
        end
        chk("busy", 32'(busy), 32'(cActive));
        chk("doneM", 32'(doneM), 32'(cDone));
        chk("resultM", resultM, mRes);
        chk("rdM", 32'(rdM), 32'(mRd));
        if (doneM) begin
            gotRes = resultM;
            gotLat = cyc - pAcc + 1;
        end
    end

    // Called just after a rising edge; the next rising edge is the acceptance edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        opE = op;
        op1 = a;
        op2 = b;
        rdE = rd;
        startE = 1'b1;
        pRes = model(op, a, b);
        pRd = rd;
        pAcc = cyc + 1;
        pDone = cyc + expLat(op, a, b);
        pKill = 1 << 30;
        pValid = 1'b1;
        gotLat = 0;
        @(posedge clk);
        #1;
        startE = 1'b0;
    endtask

    task automatic waitDone();
        int g;
        g = 0;
        while (cyc <= pDone && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) chk("timeout", 32'(g), 32'(0));
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit, input int litLat);
        issue(op, a, b, rd);
        waitDone();
        chk("litResult", gotRes, lit);
        chk("litLatency", 32'(gotLat), 32'(litLat));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rstBusy", 32'(busy), 32'(0));
        chk("rstResult", resultM, 32'h0);
        #1;
        rstN = 1'b1;

        // Multiply sign variants
        runOp(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, MulLat);
        runOp(3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd1, 32'h00000000, MulLat);
        runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h80000000, MulLat);
        runOp(3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h7FFFFFFF, MulLat);
        runOp(3'd0, 32'd12345, 32'd0, 5'd15, 32'h0, MulLat);
        runOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'h0, MulLat);
        runOp(3'd3, 32'h00010000, 32'h00010000, 5'd17, 32'h1, MulLat);

        // Divide, remainder and special cases
        runOp(3'd4, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFD, 33);
        runOp(3'd6, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFF, 33);
        runOp(3'd5, 32'hFFFFFFFF, 32'd16, 5'd10, 32'h0FFFFFFF, 33);
        runOp(3'd4, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd20, 32'd14, 33);
        runOp(3'd6, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd21, 32'hFFFFFFFE, 33);
        runOp(3'd4, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, 1);
        runOp(3'd6, 32'd5, 32'd0, 5'd12, 32'd5, 1);
        runOp(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1);
        runOp(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h0, 1);
        runOp(3'd5, 32'd7, 32'd0, 5'd18, 32'hFFFFFFFF, 1);
        runOp(3'd7, 32'd7, 32'd0, 5'd19, 32'd7, 1);
        runOp(3'd7, 32'd100, 32'd7, 5'd0, 32'd2, 33);

        // Flush at cycle 10 of a DIV, with an ignored StartE beforehand
        issue(3'd4, 32'd100, 32'd7, 5'd3);
        repeat (3) begin @(posedge clk); #1; end
        startE = 1'b1; opE = 3'd0; op1 = 32'd2; op2 = 32'd2; rdE = 5'd30;
        @(posedge clk); #1;
        startE = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        flush = 1'b1;
        pKill = cyc + 1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (XLEN + 4) begin @(posedge clk); #1; end
        chk("flushNoDone", 32'(gotLat), 32'(0));

        // StartE while busy is ignored; the first operation's result is delivered
        issue(3'd5, 32'd1000, 32'd10, 5'd4);
        repeat (5) begin @(posedge clk); #1; end
        startE = 1'b1; opE = 3'd6; op1 = 32'd9; op2 = 32'd4; rdE = 5'd31;
        @(posedge clk); #1;
        startE = 1'b0;
        waitDone();
        chk("busyStartRes", gotRes, 32'd100);
        chk("busyStartLat", 32'(gotLat), 32'(33));

        // Flush together with StartE in IDLE does not accept
        gotLat = 0;
        startE = 1'b1; flush = 1'b1; opE = 3'd4; op1 = 32'd5; op2 = 32'd0; rdE = 5'd22;
        @(posedge clk); #1;
        startE = 1'b0; flush = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("flushStartNoDone", 32'(gotLat), 32'(0));

        // Flush in DONE still presents the pulse
        issue(3'd4, 32'd5, 32'd0, 5'd6);
        flush = 1'b1;
        pKill = cyc + 1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flushDoneLat", 32'(gotLat), 32'(1));
        chk("flushDoneRes", gotRes, 32'hFFFFFFFF);
        @(posedge clk); #1;

        // Asynchronous reset at cycle 5 of a MUL, then a fresh MUL
        issue(3'd0, 32'd9, 32'd9, 5'd7);
        repeat (4) begin @(posedge clk); #1; end
        #2;
        rstN = 1'b0;
        pValid = 1'b0;
        mRes = '0;
        mRd = '0;
        #1;
        chk("asyncRstBusy", 32'(busy), 32'(0));
        chk("asyncRstDone", 32'(doneM), 32'(0));
        chk("asyncRstResult", resultM, 32'h0);
        chk("asyncRstRd", 32'(rdM), 32'(0));
        @(negedge clk);
        #1;
        rstN = 1'b1;
        runOp(3'd0, 32'd3, 32'd4, 5'd9, 32'd12, MulLat);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32m_muldiv_unit.md
RV32M_MULDIV_UNIT -- requirements
Module: rv32m_muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have port: CPU_CLK  in  1  single clock, rising-edge.
REQ-003 SHALL have port: CPU_RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: StartE  in  1  request to accept a new operation.
REQ-005 SHALL have port: OpE  in  3  RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 SHALL have ports: Operand1 and Operand2, both in, XLEN wide, rs1 and rs2 values.
REQ-007 SHALL have port: RdE  in  5  destination register tag.
REQ-008 SHALL have port: Flush  in  1  abort the current or requested operation.
REQ-009 SHALL have port: Busy  out  1  operation in progress; the hazard unit uses it to stall F/D/E.
REQ-010 SHALL have port: DoneM  out  1  single-cycle result-valid pulse.
REQ-011 SHALL have port: ResultM  out  XLEN  result.
REQ-012 SHALL have port: RdM  out  5  tag captured with the accepted operation.

Function
REQ-013 SHALL have states: IDLE, MUL, DIV, DONE; Busy = (state != IDLE).
REQ-014 SHALL accept an operation only in IDLE with StartE=1 and Flush=0; operands, OpE and RdE are registered at acceptance.
REQ-015 SHALL ignore StartE in MUL, DIV and DONE; there is no queueing.
REQ-016 Multiply SHALL use an iterative shift-add over unsigned magnitudes, one bit per cycle, for XLEN cycles in MUL, then go to DONE.
REQ-017 Multiply sign rules: MUL/MULH treat both operands as signed; MULHSU treats Operand1 as signed and Operand2 as unsigned; MULHU treats both as unsigned; the 2*XLEN product is negated at the end when the result sign is negative.
REQ-018 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-019 Divide SHALL use restoring division over magnitudes, one quotient bit per cycle, for XLEN cycles in DIV, then go to DONE.
REQ-020 Divide signs: quotient is negated when operand signs differ; remainder takes the dividend's sign.
REQ-021 Divide by zero SHALL be detected at acceptance and go directly to DONE with quotient all-ones and remainder equal to the dividend.
REQ-022 Signed overflow (-2^(XLEN-1) / -1) SHALL be detected at acceptance and go directly to DONE with quotient -2^(XLEN-1) and remainder 0.
REQ-023 Latency, counting the acceptance edge as cycle 0: iterative op gives DoneM=1 in cycle XLEN+1; the special cases in REQ-021/022 give DoneM=1 in cycle 1.
REQ-024 In DONE, DoneM=1 and ResultM/RdM are valid for exactly one cycle; the next state is always IDLE; there is no back-pressure.
REQ-025 ResultM and RdM SHALL hold their last value outside DONE; DoneM=0 outside DONE.
REQ-026 Flush=1 in any state SHALL force IDLE on the next edge with no DoneM pulse; Flush together with StartE in IDLE SHALL not accept.
REQ-027 Flush in DONE SHALL still allow the DoneM pulse already being presented in that cycle, then return to IDLE.
REQ-028 The iteration counter SHALL be clog2(XLEN)+1 bits wide, SHALL be loaded at acceptance, and SHALL not wrap.
REQ-029 An operation with Rd=0 SHALL complete normally; suppressing the register write is the writeback stage's job.

Reset
REQ-030 CPU_RST_N=0 SHALL asynchronously force IDLE, Busy=0, DoneM=0, ResultM=0, RdM=0, the counter to 0 and all datapath registers to 0, including mid-operation.
REQ-031 After CPU_RST_N is released, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-032 Macro MULDIV_FAST_MUL_EN defined: multiply SHALL use a single-cycle combinational 2*XLEN multiplier; MUL goes to DONE after 1 cycle and DoneM comes in cycle 2; divide is unchanged.
REQ-033 MULDIV_FAST_MUL_EN undefined: multiply SHALL be iterative per REQ-016 with latency XLEN+1; the port list is identical in both builds.

Verification
REQ-034 MUL 7 x -3, XLEN=32 -> DoneM at cycle 33, ResultM=0xFFFFFFEB, RdM equal to the RdE captured at accept; with the macro, DoneM at cycle 2.
REQ-035 MULH/MULHSU/MULHU with 0x80000000 x 0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
REQ-036 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF; each with DoneM at cycle 33.
REQ-037 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0; DoneM at cycle 1 in both cases.
REQ-038 Flush asserted at cycle 10 of a DIV -> IDLE at cycle 11 with no DoneM; a StartE issued during Busy is ignored and the result matches the first operation only.
REQ-039 CPU_RST_N pulsed low at cycle 5 of a MUL -> all outputs 0 immediately; a fresh MUL 3 x 4 then returns 12.
